// File: rtl/lpif_ustrm_pkg.sv
// rtl/lpif_ustrm_pkg.sv - shared widths, entry layout and reset state for the upstream rx buffer
package lpif_ustrm_pkg;

  localparam int DATA_W   = 256;
  localparam int CRC_W    = 16;
  localparam int PROTID_W = 2;
  localparam int STATE_W  = 4;
  localparam int ENTRY_W  = PROTID_W + 1 + CRC_W + DATA_W;

  localparam logic [STATE_W-1:0] STATE_RESET = 4'h0;

  typedef struct packed {
    logic [PROTID_W-1:0] protid;
    logic                crc_valid;
    logic [CRC_W-1:0]    crc;
    logic [DATA_W-1:0]   data;
  } ustrm_entry_t;

endpackage

// File: rtl/lpif_ustrm_rx_buffer_if.sv
// rtl/lpif_ustrm_rx_buffer_if.sv - upstream beat stream in, protocol-layer handshake out
interface lpif_ustrm_rx_buffer_if;
  import lpif_ustrm_pkg::*;

  logic [STATE_W-1:0]  ustrm_state;
  logic [PROTID_W-1:0] ustrm_protid;
  logic [DATA_W-1:0]   ustrm_data;
  logic                ustrm_dvalid;
  logic [CRC_W-1:0]    ustrm_crc;
  logic                ustrm_crc_valid;
  logic                ustrm_valid;

  logic                pl_valid;
  logic                pl_ready;
  logic [DATA_W-1:0]   pl_data;
  logic [PROTID_W-1:0] pl_protid;
  logic [CRC_W-1:0]    pl_crc;
  logic                pl_crc_valid;

  modport master (
    output ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid,
           ustrm_crc, ustrm_crc_valid, ustrm_valid, pl_ready,
    input  pl_valid, pl_data, pl_protid, pl_crc, pl_crc_valid
  );

  modport slave (
    input  ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid,
           ustrm_crc, ustrm_crc_valid, ustrm_valid, pl_ready,
    output pl_valid, pl_data, pl_protid, pl_crc, pl_crc_valid
  );

endinterface

// File: rtl/lpif_ustrm_fifo_mem.sv
// rtl/lpif_ustrm_fifo_mem.sv - register-array storage, one write port, asynchronous read
module lpif_ustrm_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 275,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lpif_ustrm_rx_buffer.sv
// rtl/lpif_ustrm_rx_buffer.sv - buffers upstream LPIF beats, tracks link state, returns credits
module lpif_ustrm_rx_buffer
  import lpif_ustrm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk_wr,
  input  logic                  rst_wr_n,
  input  logic                  rx_online,
  lpif_ustrm_rx_buffer_if.slave ustrm_if,
  output logic [STATE_W-1:0]    pl_state,
  output logic                  pl_state_chg,
  output logic                  credit_return,
  output logic [LVL_W-1:0]      fifo_level,
  input  logic                  clear_status,
  output logic [31:0]           debug_status
);

  localparam int AW = $clog2(DEPTH);

  logic [LVL_W-1:0] wr_ptr;
  logic [LVL_W-1:0] rd_ptr;
  logic             full;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             drop;
  logic             overflow_sticky;
  logic [7:0]       drop_cnt;
  ustrm_entry_t     wr_entry;
  ustrm_entry_t     rd_entry;

  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (wr_ptr[LVL_W-1] != rd_ptr[LVL_W-1]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign push_req = rx_online & ustrm_if.ustrm_valid & ustrm_if.ustrm_dvalid;
  assign pop      = ustrm_if.pl_valid & ustrm_if.pl_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign wr_entry.protid    = ustrm_if.ustrm_protid;
  assign wr_entry.crc_valid = ustrm_if.ustrm_crc_valid;
  assign wr_entry.crc       = ustrm_if.ustrm_crc;
  assign wr_entry.data      = ustrm_if.ustrm_data;

  lpif_ustrm_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (AW)
  ) u_mem (
    .clk   (clk_wr),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  // Storage is unreset, so the head is masked while empty to keep outputs clean.
  assign ustrm_if.pl_valid     = (fifo_level != '0);
  assign ustrm_if.pl_data      = ustrm_if.pl_valid ? rd_entry.data      : '0;
  assign ustrm_if.pl_protid    = ustrm_if.pl_valid ? rd_entry.protid    : '0;
  assign ustrm_if.pl_crc       = ustrm_if.pl_valid ? rd_entry.crc       : '0;
  assign ustrm_if.pl_crc_valid = ustrm_if.pl_valid ? rd_entry.crc_valid : 1'b0;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      credit_return <= 1'b0;
    end else begin
      credit_return <= pop;
      if (!rx_online) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + LVL_W'(1);
        if (pop)  rd_ptr <= rd_ptr + LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      pl_state     <= STATE_RESET;
      pl_state_chg <= 1'b0;
    end else if (!rx_online) begin
      pl_state     <= STATE_RESET;
      pl_state_chg <= 1'b0;
    end else if (ustrm_if.ustrm_valid) begin
      pl_state     <= ustrm_if.ustrm_state;
      pl_state_chg <= (ustrm_if.ustrm_state != pl_state);
    end else begin
      pl_state_chg <= 1'b0;
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      overflow_sticky <= 1'b0;
      drop_cnt        <= 8'h00;
    end else if (clear_status) begin
      overflow_sticky <= 1'b0;
      drop_cnt        <= 8'h00;
    end else if (drop) begin
      overflow_sticky <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
    end
  end

  assign debug_status = {overflow_sticky, 7'h00, drop_cnt, 8'h00, 8'(fifo_level)};

endmodule

// File: tb/tb_lpif_ustrm_rx_buffer.sv
// tb/tb_lpif_ustrm_rx_buffer.sv - vector table plus directed corner sequences for the rx buffer
module tb_lpif_ustrm_rx_buffer;
  import lpif_ustrm_pkg::*;

  localparam int DEPTH = 8;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk_wr = 1'b0;
  logic             rst_wr_n;
  logic             rx_online;
  logic [3:0]       pl_state;
  logic             pl_state_chg;
  logic             credit_return;
  logic [LVL_W-1:0] fifo_level;
  logic             clear_status;
  logic [31:0]      debug_status;

  int vectors = 0;
  int miscompares = 0;

  lpif_ustrm_rx_buffer_if ifc ();

  lpif_ustrm_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk_wr        (clk_wr),
    .rst_wr_n      (rst_wr_n),
    .rx_online     (rx_online),
    .ustrm_if      (ifc.slave),
    .pl_state      (pl_state),
    .pl_state_chg  (pl_state_chg),
    .credit_return (credit_return),
    .fifo_level    (fifo_level),
    .clear_status  (clear_status),
    .debug_status  (debug_status)
  );

  always #5 clk_wr = ~clk_wr;

  typedef struct {
    logic        rx;
    logic        v;
    logic        dv;
    logic [31:0] data;
    logic [1:0]  pid;
    logic [15:0] crc;
    logic        crcv;
    logic [3:0]  st;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_data;
    logic [1:0]  e_pid;
    logic [15:0] e_crc;
    logic        e_crcv;
    logic [3:0]  e_state;
    logic        e_chg;
    logic        e_credit;
    logic [3:0]  e_level;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_wr);
  endtask

  task automatic drive(input logic v, input logic dv, input logic [31:0] data,
                       input logic [1:0] pid, input logic [15:0] crc, input logic crcv,
                       input logic [3:0] st);
    ifc.ustrm_valid     = v;
    ifc.ustrm_dvalid    = dv;
    ifc.ustrm_data      = 256'(data);
    ifc.ustrm_protid    = pid;
    ifc.ustrm_crc       = crc;
    ifc.ustrm_crc_valid = crcv;
    ifc.ustrm_state     = st;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 2'd0, 16'h0, 1'b0, 4'h0);
  endtask

  initial begin
    rst_wr_n     = 1'b0;
    rx_online    = 1'b0;
    clear_status = 1'b0;
    ifc.pl_ready = 1'b0;
    idle();

    //          rx v  dv data   pid crc      cv st  rdy | ev  edata  ep  ecrc     ecv est chg cr lvl
    vecs[0]  = '{1, 1, 1, 32'h11, 1, 16'hA011, 1, 0, 1,   0, 32'h0,  0, 16'h0,    0, 0,  0,  0, 0};
    vecs[1]  = '{1, 1, 1, 32'h22, 1, 16'hA022, 0, 0, 1,   1, 32'h11, 1, 16'hA011, 1, 0,  0,  0, 1};
    vecs[2]  = '{1, 1, 1, 32'h33, 1, 16'hA033, 1, 0, 1,   1, 32'h22, 1, 16'hA022, 0, 0,  0,  1, 1};
    vecs[3]  = '{1, 0, 0, 32'h0,  0, 16'h0,    0, 0, 1,   1, 32'h33, 1, 16'hA033, 1, 0,  0,  1, 1};
    vecs[4]  = '{1, 0, 0, 32'h0,  0, 16'h0,    0, 0, 1,   0, 32'h0,  0, 16'h0,    0, 0,  0,  1, 0};
    vecs[5]  = '{1, 0, 0, 32'h0,  0, 16'h0,    0, 0, 1,   0, 32'h0,  0, 16'h0,    0, 0,  0,  0, 0};
    vecs[6]  = '{1, 1, 0, 32'hDE, 3, 16'hBEEF, 1, 0, 1,   0, 32'h0,  0, 16'h0,    0, 0,  0,  0, 0};
    vecs[7]  = '{1, 1, 0, 32'hDE, 3, 16'hBEEF, 1, 3, 1,   0, 32'h0,  0, 16'h0,    0, 0,  0,  0, 0};
    vecs[8]  = '{1, 1, 0, 32'hDE, 3, 16'hBEEF, 1, 3, 1,   0, 32'h0,  0, 16'h0,    0, 3,  1,  0, 0};
    vecs[9]  = '{1, 1, 0, 32'hDE, 3, 16'hBEEF, 1, 1, 1,   0, 32'h0,  0, 16'h0,    0, 3,  0,  0, 0};
    vecs[10] = '{1, 0, 0, 32'h0,  0, 16'h0,    0, 0, 1,   0, 32'h0,  0, 16'h0,    0, 1,  1,  0, 0};
    vecs[11] = '{1, 0, 0, 32'h0,  0, 16'h0,    0, 0, 1,   0, 32'h0,  0, 16'h0,    0, 1,  0,  0, 0};

    tick();
    tick();
    #1;
    check("reset_pl_valid", 256'(ifc.pl_valid), 256'(0));
    check("reset_pl_data", ifc.pl_data, 256'(0));
    check("reset_level", 256'(fifo_level), 256'(0));
    check("reset_debug", 256'(debug_status), 256'(0));
    check("reset_credit", 256'(credit_return), 256'(0));
    check("reset_state", 256'(pl_state), 256'(0));
    tick();
    rst_wr_n = 1'b1;
    tick();

    // Back-to-back beats with immediate consumption, then state-only updates.
    for (int i = 0; i < 12; i++) begin
      rx_online    = vecs[i].rx;
      ifc.pl_ready = vecs[i].rdy;
      drive(vecs[i].v, vecs[i].dv, vecs[i].data, vecs[i].pid, vecs[i].crc, vecs[i].crcv, vecs[i].st);
      #1;
      check($sformatf("v%0d_valid", i),  256'(ifc.pl_valid),     256'(vecs[i].e_valid));
      check($sformatf("v%0d_data", i),   ifc.pl_data,            256'(vecs[i].e_data));
      check($sformatf("v%0d_protid", i), 256'(ifc.pl_protid),    256'(vecs[i].e_pid));
      check($sformatf("v%0d_crc", i),    256'(ifc.pl_crc),       256'(vecs[i].e_crc));
      check($sformatf("v%0d_crcv", i),   256'(ifc.pl_crc_valid), 256'(vecs[i].e_crcv));
      check($sformatf("v%0d_state", i),  256'(pl_state),         256'(vecs[i].e_state));
      check($sformatf("v%0d_chg", i),    256'(pl_state_chg),     256'(vecs[i].e_chg));
      check($sformatf("v%0d_credit", i), 256'(credit_return),    256'(vecs[i].e_credit));
      check($sformatf("v%0d_level", i),  256'(fifo_level),       256'(vecs[i].e_level));
      tick();
    end

    // Overflow: 10 beats into 8 slots, then drain and clear status.
    ifc.pl_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 32'(100 + i), 2'd2, 16'(i), 1'b1, 4'h1);
      tick();
    end
    idle();
    #1;
    check("ovf_level", 256'(fifo_level), 256'(8));
    check("ovf_debug", 256'(debug_status), 256'(32'h8002_0008));
    ifc.pl_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("ovf_data%0d", i), ifc.pl_data, 256'(100 + i));
      check($sformatf("ovf_crc%0d", i), 256'(ifc.pl_crc), 256'(i));
      if (i > 0) check($sformatf("ovf_credit%0d", i), 256'(credit_return), 256'(1));
      tick();
    end
    #1;
    check("ovf_drained_valid", 256'(ifc.pl_valid), 256'(0));
    check("ovf_last_credit", 256'(credit_return), 256'(1));
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    #1;
    check("clear_debug", 256'(debug_status), 256'(0));
    check("clear_credit", 256'(credit_return), 256'(0));

    // Full FIFO with push and pop in the same cycle.
    ifc.pl_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 32'(200 + i), 2'd3, 16'h0, 1'b0, 4'h1);
      tick();
    end
    drive(1'b1, 1'b1, 32'h300, 2'd3, 16'h0, 1'b0, 4'h1);
    ifc.pl_ready = 1'b1;
    tick();
    idle();
    #1;
    check("pp_level", 256'(fifo_level), 256'(8));
    check("pp_debug", 256'(debug_status), 256'(32'h0000_0008));
    check("pp_credit", 256'(credit_return), 256'(1));
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("pp_data%0d", i), ifc.pl_data, (i < 7) ? 256'(201 + i) : 256'(32'h300));
      tick();
    end
    #1;
    check("pp_empty", 256'(fifo_level), 256'(0));

    // Drop counter saturation, and clear beating a same-cycle overflow.
    ifc.pl_ready = 1'b0;
    drive(1'b1, 1'b1, 32'h5A, 2'd0, 16'h0, 1'b0, 4'h1);
    for (int i = 0; i < 266; i++) tick();
    #1;
    check("sat_debug", 256'(debug_status), 256'(32'h80FF_0008));
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    #1;
    check("clr_prio_debug", 256'(debug_status), 256'(32'h0000_0008));
    tick();
    #1;
    check("post_clr_debug", 256'(debug_status), 256'(32'h8001_0008));
    idle();
    rx_online = 1'b0;
    tick();
    rx_online = 1'b1;
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;

    // Flush with rx_online low for one cycle.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 32'(500 + i), 2'd1, 16'h0, 1'b0, 4'h2);
      tick();
    end
    idle();
    #1;
    check("fl_level5", 256'(fifo_level), 256'(5));
    check("fl_state2", 256'(pl_state), 256'(2));
    rx_online = 1'b0;
    tick();
    rx_online = 1'b1;
    #1;
    check("fl_valid", 256'(ifc.pl_valid), 256'(0));
    check("fl_level", 256'(fifo_level), 256'(0));
    check("fl_state", 256'(pl_state), 256'(0));
    check("fl_chg", 256'(pl_state_chg), 256'(0));
    check("fl_credit", 256'(credit_return), 256'(0));
    tick();
    #1;
    check("fl_credit2", 256'(credit_return), 256'(0));
    drive(1'b1, 1'b1, 32'h55, 2'd1, 16'h1234, 1'b1, 4'h2);
    tick();
    idle();
    #1;
    check("res_data", ifc.pl_data, 256'(32'h55));
    check("res_level", 256'(fifo_level), 256'(1));
    check("res_chg", 256'(pl_state_chg), 256'(1));
    ifc.pl_ready = 1'b1;
    rx_online    = 1'b0;
    tick();
    #1;
    check("fallpop_credit", 256'(credit_return), 256'(1));
    check("fallpop_valid", 256'(ifc.pl_valid), 256'(0));
    check("fallpop_state", 256'(pl_state), 256'(0));
    rx_online = 1'b1;
    tick();
    #1;
    check("fallpop_credit2", 256'(credit_return), 256'(0));

    // Asynchronous reset while full and still pushing.
    ifc.pl_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 32'(400 + i), 2'd2, 16'hFFFF, 1'b1, 4'h5);
      tick();
    end
    #1;
    check("pre_rst_level", 256'(fifo_level), 256'(8));
    #2;
    rst_wr_n = 1'b0;
    #1;
    check("arst_valid", 256'(ifc.pl_valid), 256'(0));
    check("arst_data", ifc.pl_data, 256'(0));
    check("arst_level", 256'(fifo_level), 256'(0));
    check("arst_debug", 256'(debug_status), 256'(0));
    check("arst_state", 256'(pl_state), 256'(0));
    idle();
    tick();
    rst_wr_n = 1'b1;
    drive(1'b1, 1'b1, 32'h77, 2'd1, 16'h0077, 1'b0, 4'h0);
    tick();
    idle();
    #1;
    check("post_rst_data", ifc.pl_data, 256'(32'h77));
    check("post_rst_crcv", 256'(ifc.pl_crc_valid), 256'(0));
    check("post_rst_level", 256'(fifo_level), 256'(1));
    ifc.pl_ready = 1'b1;
    tick();
    #1;
    check("post_rst_empty", 256'(ifc.pl_valid), 256'(0));
    check("post_rst_credit", 256'(credit_return), 256'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
